// File: rtl/uart_rx.sv
// UART receive engine: oversampled start/data/two-stop frame reconstruction.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx #(
  parameter int DATA_BW     = 8,
  parameter int DATA_BW_BIT = 4,
  parameter int OVERSAMPLE  = 16,
  parameter int OS_BW       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               RX,
  output logic [DATA_BW-1:0] data_out,
  output logic               valid,
  output logic               frame_err,
  output logic               busy
);

  localparam logic [OS_BW-1:0]       HALF_PT  = OS_BW'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_BW-1:0]       FULL_PT  = OS_BW'(OVERSAMPLE - 1);
  localparam logic [DATA_BW_BIT-1:0] LAST_BIT = DATA_BW_BIT'(DATA_BW - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP_1, STOP_2} state_t;

  state_t                 state;
  logic [OS_BW-1:0]       os_cnt;
  logic [DATA_BW_BIT-1:0] bit_cnt;
  logic [DATA_BW-1:0]     shreg;
  logic                   err;
  logic                   rx_meta, rx_s;
  logic [OS_BW-1:0]       sample_pt;
  logic                   at_pt;
  logic                   sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  assign sample_pt = (state == START) ? HALF_PT : FULL_PT;
  assign at_pt     = (os_cnt == sample_pt);
  assign busy      = (state != IDLE);

`ifdef UART_RX_MAJORITY_EN
  // Two earlier looks at rx_s, taken one and two ticks before the sample point.
  logic [1:0] win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win <= 2'b11;
    end else if (tick) begin
      if (os_cnt == sample_pt - OS_BW'(2)) win[0] <= rx_s;
      if (os_cnt == sample_pt - OS_BW'(1)) win[1] <= rx_s;
    end
  end

  assign sample = (win[0] & win[1]) | (win[0] & rx_s) | (win[1] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      err       <= 1'b0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state  <= START;
              os_cnt <= '0;
            end
          end
          START: begin
            if (at_pt) begin
              os_cnt <= '0;
              if (!sample) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              os_cnt <= os_cnt + OS_BW'(1);
            end
          end
          DATA: begin
            if (at_pt) begin
              // LSB-first shift: after DATA_BW samples bit 0 sits at the LSB.
              shreg  <= {sample, shreg[DATA_BW-1:1]};
              os_cnt <= '0;
              if (bit_cnt == LAST_BIT) state <= STOP_1;
              else bit_cnt <= bit_cnt + DATA_BW_BIT'(1);
            end else begin
              os_cnt <= os_cnt + OS_BW'(1);
            end
          end
          STOP_1: begin
            if (at_pt) begin
              err    <= !sample;
              os_cnt <= '0;
              state  <= STOP_2;
            end else begin
              os_cnt <= os_cnt + OS_BW'(1);
            end
          end
          STOP_2: begin
            if (at_pt) begin
              data_out  <= shreg;
              valid     <= 1'b1;
              frame_err <= err | !sample;
              os_cnt    <= '0;
              state     <= IDLE;
            end else begin
              os_cnt <= os_cnt + OS_BW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every clk, frames driven bit-serially on RX.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic       RX = 1'b1;
  logic [7:0] data_out;
  logic       valid, frame_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  int         valid_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_err = 1'b0;
  logic       prev_valid = 1'b0;
  int         wide_cnt = 0;
  logic       busy_seen = 1'b0;
  logic       mid_busy = 1'b0;

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .RX        (RX),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt = valid_cnt + 1;
      last_data = data_out;
      last_err  = frame_err;
      if (prev_valid) wide_cnt = wide_cnt + 1;
    end
    if (busy) busy_seen = 1'b1;
    prev_valid = valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic s1, input logic s2);
    return {s2, s1, d, 1'b0};
  endfunction

  // Drive ncyc intervals of the frame (16 clk per bit); glitch_iv forces RX high for one clk.
  task automatic send_bits(input logic [10:0] bits, input int ncyc, input int glitch_iv);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      RX = (i == glitch_iv) ? 1'b1 : bits[i / 16];
      if (i == 80) mid_busy = busy;
    end
  endtask

  task automatic idle_clks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      RX = 1'b1;
    end
  endtask

  int vc;
  logic [7:0] glitch_exp;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_frame_err", {31'b0, frame_err}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_data", {24'b0, data_out}, 32'd0);
    rst = 1'b0;
    idle_clks(5);

    // 0xA5 clean frame
    mid_busy = 1'b0;
    send_bits(mk_frame(8'hA5, 1'b1, 1'b1), 176, -1);
    check("a5_cnt", valid_cnt, 32'd1);
    check("a5_data", {24'b0, last_data}, 32'hA5);
    check("a5_err", {31'b0, last_err}, 32'd0);
    check("a5_busy_mid", {31'b0, mid_busy}, 32'd1);
    check("a5_busy_after", {31'b0, busy}, 32'd0);
    check("a5_held", {24'b0, data_out}, 32'hA5);
    idle_clks(10);

    // back-to-back 0x00 then 0xFF
    send_bits(mk_frame(8'h00, 1'b1, 1'b1), 176, -1);
    check("b2b0_cnt", valid_cnt, 32'd2);
    check("b2b0_data", {24'b0, last_data}, 32'h00);
    check("b2b0_err", {31'b0, last_err}, 32'd0);
    send_bits(mk_frame(8'hFF, 1'b1, 1'b1), 176, -1);
    check("b2b1_cnt", valid_cnt, 32'd3);
    check("b2b1_data", {24'b0, last_data}, 32'hFF);
    check("b2b1_err", {31'b0, last_err}, 32'd0);
    idle_clks(10);

    // start glitch: 4 ticks low
    busy_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      RX = 1'b0;
    end
    idle_clks(40);
    check("glitch_cnt", valid_cnt, 32'd3);
    check("glitch_busy_seen", {31'b0, busy_seen}, 32'd1);
    check("glitch_busy_after", {31'b0, busy}, 32'd0);

    // stop bit error then clean frame
    send_bits(mk_frame(8'h3C, 1'b0, 1'b1), 176, -1);
    check("ferr_cnt", valid_cnt, 32'd4);
    check("ferr_data", {24'b0, last_data}, 32'h3C);
    check("ferr_err", {31'b0, last_err}, 32'd1);
    idle_clks(10);
    send_bits(mk_frame(8'h12, 1'b1, 1'b1), 176, -1);
    check("clean_cnt", valid_cnt, 32'd5);
    check("clean_data", {24'b0, last_data}, 32'h12);
    check("clean_err", {31'b0, last_err}, 32'd0);
    idle_clks(10);

    // reset during data bit 4 (frame position 5)
    vc = valid_cnt;
    send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 88, -1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_data", {24'b0, data_out}, 32'd0);
    RX = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_clks(200);
    check("rst_no_valid", valid_cnt, vc);
    send_bits(mk_frame(8'h81, 1'b1, 1'b1), 176, -1);
    check("post_rst_cnt", valid_cnt, vc + 1);
    check("post_rst_data", {24'b0, last_data}, 32'h81);
    check("post_rst_err", {31'b0, last_err}, 32'd0);
    idle_clks(10);

    // 1-clk high glitch at the centre of data bit 3 (frame position 4, interval 72)
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    send_bits(mk_frame(8'h00, 1'b1, 1'b1), 176, 72);
    check("mid_glitch_cnt", valid_cnt, vc + 2);
    check("mid_glitch_data", {24'b0, last_data}, {24'b0, glitch_exp});
    idle_clks(10);

    check("valid_one_clk", wide_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
